cu_setup_resp_sink: RTL and testbench



---
 rtl/cu_setup_resp_sink.sv | 159 +++++++++++++++
 tb/tb_cu_setup_resp_sink.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cu_setup_resp_sink.sv
// ============================================================================
// Module   : cu_setup_resp_sink
// Purpose  : Lands configuration read-response beats into an indexed register
//            file and flags completion after the requested beat count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cu_setup_resp_sink #(
    parameter  int DATA_W    = 32,
    parameter  int CFG_WORDS = 8,
    parameter  int CNT_W     = 16,
    localparam int IDX_W     = $clog2(CFG_WORDS) + 1
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic                        start_in,
    input  logic [CNT_W-1:0]            num_beats_in,
    input  logic                        pause_in,
    input  logic                        flush_in,
    input  logic                        resp_valid_in,
    output logic                        resp_ready_out,
    input  logic [IDX_W-1:0]            resp_idx_in,
    input  logic [DATA_W-1:0]           resp_data_in,
    output logic [CFG_WORDS*DATA_W-1:0] cfg_out,
    output logic                        cfg_valid_out,
    output logic                        done_out,
    output logic                        busy_out,
    output logic                        error_out,
    output logic [5:0]                  state_out
);

    localparam logic [5:0] RSP_RESET = 6'b000001;
    localparam logic [5:0] RSP_IDLE  = 6'b000010;
    localparam logic [5:0] RSP_BUSY  = 6'b000100;
    localparam logic [5:0] RSP_PAUSE = 6'b001000;
    localparam logic [5:0] RSP_DONE  = 6'b010000;
    localparam logic [5:0] RSP_FLUSH = 6'b100000;

    logic [5:0]        r_state_q,     w_state_d;
    logic [CNT_W-1:0]  r_cnt_q,       w_cnt_d;
    logic [CNT_W-1:0]  r_target_q,    w_target_d;
    logic              r_cfg_valid_q, w_cfg_valid_d;
    logic              r_error_q,     w_error_d;
    logic [DATA_W-1:0] r_cfg_q [CFG_WORDS];
    logic [DATA_W-1:0] w_cfg_d [CFG_WORDS];

    logic w_hs;
    logic w_in_range;
    logic w_last;
    logic w_wr_en;

    // Ready depends only on the state register so no valid->ready path exists.
    assign resp_ready_out = (r_state_q == RSP_BUSY) || (r_state_q == RSP_FLUSH);
    assign done_out       = (r_state_q == RSP_DONE);
    assign busy_out       = (r_state_q == RSP_BUSY) || (r_state_q == RSP_PAUSE) ||
                            (r_state_q == RSP_FLUSH);
    assign cfg_valid_out  = r_cfg_valid_q;
    assign error_out      = r_error_q;
    assign state_out      = r_state_q;

    assign w_hs       = resp_valid_in && resp_ready_out;
    assign w_in_range = resp_idx_in < IDX_W'(CFG_WORDS);
    assign w_last     = (r_cnt_q + CNT_W'(1)) == r_target_q;

    always_comb begin
        w_state_d     = r_state_q;
        w_cnt_d       = r_cnt_q;
        w_target_d    = r_target_q;
        w_cfg_valid_d = r_cfg_valid_q;
        w_error_d     = r_error_q;
        w_wr_en       = 1'b0;
        case (r_state_q)
            RSP_RESET: w_state_d = RSP_IDLE;
            RSP_IDLE: begin
                if (start_in) begin
                    w_target_d    = num_beats_in;
                    w_cnt_d       = '0;
                    w_error_d     = 1'b0;
                    // A zero-length request completes without touching the channel.
                    w_cfg_valid_d = (num_beats_in == '0);
                    w_state_d     = (num_beats_in == '0) ? RSP_DONE : RSP_BUSY;
                end
            end
            RSP_BUSY: begin
                if (flush_in) begin
                    w_state_d     = RSP_FLUSH;
                    w_cfg_valid_d = 1'b0;
                end else begin
                    if (w_hs) begin
                        w_cnt_d = r_cnt_q + CNT_W'(1);
                        if (w_in_range) w_wr_en   = 1'b1;
                        else            w_error_d = 1'b1;
                    end
                    if (w_hs && w_last) begin
                        w_state_d     = RSP_DONE;
                        w_cfg_valid_d = 1'b1;
                    end else if (pause_in) begin
                        w_state_d = RSP_PAUSE;
                    end
                end
            end
            RSP_PAUSE: begin
                if (flush_in) begin
                    w_state_d     = RSP_FLUSH;
                    w_cfg_valid_d = 1'b0;
                end else if (!pause_in) begin
                    w_state_d = RSP_BUSY;
                end
            end
            RSP_DONE:  w_state_d = RSP_IDLE;
            RSP_FLUSH: begin
                w_cfg_valid_d = 1'b0;
                if (!flush_in) w_state_d = RSP_IDLE;
            end
            default:   w_state_d = RSP_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < CFG_WORDS; i++) begin
            w_cfg_d[i] = r_cfg_q[i];
        end
        if (w_wr_en) begin
            w_cfg_d[resp_idx_in[IDX_W-2:0]] = resp_data_in;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state_q     <= RSP_RESET;
            r_cnt_q       <= '0;
            r_target_q    <= '0;
            r_cfg_valid_q <= 1'b0;
            r_error_q     <= 1'b0;
            for (int i = 0; i < CFG_WORDS; i++) begin
                r_cfg_q[i] <= '0;
            end
        end else begin
            r_state_q     <= w_state_d;
            r_cnt_q       <= w_cnt_d;
            r_target_q    <= w_target_d;
            r_cfg_valid_q <= w_cfg_valid_d;
            r_error_q     <= w_error_d;
            for (int i = 0; i < CFG_WORDS; i++) begin
                r_cfg_q[i] <= w_cfg_d[i];
            end
        end
    end

    generate
        for (genvar g = 0; g < CFG_WORDS; g++) begin : g_cfg_flat
            assign cfg_out[g*DATA_W +: DATA_W] = r_cfg_q[g];
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_cu_setup_resp_sink.sv
// Bench for cu_setup_resp_sink: directed lifecycle scenarios plus randomized
// runs scored against an abstract model of the register file and handshakes.
`default_nettype none

module tb_cu_setup_resp_sink;

    localparam logic [5:0] S_RESET = 6'd1, S_IDLE = 6'd2, S_BUSY = 6'd4,
                           S_PAUSE = 6'd8, S_DONE = 6'd16, S_FLUSH = 6'd32;

    logic         ap_clk = 1'b0;
    logic         ap_rst_n = 1'b0;
    logic         start_in = 1'b0;
    logic [15:0]  num_beats_in = '0;
    logic         pause_in = 1'b0;
    logic         flush_in = 1'b0;
    logic         resp_valid_in = 1'b0;
    logic         resp_ready_out;
    logic [3:0]   resp_idx_in = '0;
    logic [31:0]  resp_data_in = '0;
    logic [255:0] cfg_out;
    logic         cfg_valid_out, done_out, busy_out, error_out;
    logic [5:0]   state_out;

    logic [31:0]  m_cfg [8];
    int           checks = 0;
    int           errors = 0;

    cu_setup_resp_sink dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start_in(start_in),
        .num_beats_in(num_beats_in), .pause_in(pause_in), .flush_in(flush_in),
        .resp_valid_in(resp_valid_in), .resp_ready_out(resp_ready_out),
        .resp_idx_in(resp_idx_in), .resp_data_in(resp_data_in), .cfg_out(cfg_out),
        .cfg_valid_out(cfg_valid_out), .done_out(done_out), .busy_out(busy_out),
        .error_out(error_out), .state_out(state_out)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic quiet();
        start_in = 0; pause_in = 0; flush_in = 0; resp_valid_in = 0;
    endtask

    task automatic start_run(input int n);
        start_in = 1; num_beats_in = 16'(n);
        tick();
        start_in = 0;
    endtask

    task automatic test_reset();
        ap_rst_n = 0; quiet();
        tick(); tick();
        for (int w = 0; w < 8; w++) m_cfg[w] = '0;
        checks++; if (state_out !== S_RESET) begin errors++; $display("FAIL reset_state got %0h want %0h", state_out, S_RESET); end
        checks++; if (cfg_out !== '0) begin errors++; $display("FAIL reset_cfg got %0h want 0", cfg_out); end
        checks++; if ({resp_ready_out, cfg_valid_out, done_out, busy_out, error_out} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b want 00000", {resp_ready_out, cfg_valid_out, done_out, busy_out, error_out}); end
        ap_rst_n = 1;
        tick();
        checks++; if (state_out !== S_IDLE) begin errors++; $display("FAIL reset_release got %0h want %0h", state_out, S_IDLE); end
    endtask

    task automatic test_basic_load();
        start_run(8);
        checks++; if (state_out !== S_BUSY || busy_out !== 1'b1) begin errors++; $display("FAIL basic_start got state %0h busy %b want 4/1", state_out, busy_out); end
        for (int i = 0; i < 8; i++) begin
            resp_valid_in = 1; resp_idx_in = 4'(i); resp_data_in = 32'hA0 + 32'(i);
            m_cfg[i] = 32'hA0 + 32'(i);
            checks++; if (resp_ready_out !== 1'b1) begin errors++; $display("FAIL basic_ready beat %0d got %b want 1", i, resp_ready_out); end
            tick();
        end
        resp_valid_in = 0;
        checks++; if (state_out !== S_DONE || done_out !== 1'b1 || cfg_valid_out !== 1'b1) begin
            errors++; $display("FAIL basic_done got state %0h done %b cfgv %b want 10/1/1", state_out, done_out, cfg_valid_out); end
        tick();
        checks++; if (state_out !== S_IDLE || done_out !== 1'b0 || cfg_valid_out !== 1'b1 || error_out !== 1'b0) begin
            errors++; $display("FAIL basic_idle got state %0h done %b cfgv %b err %b want 2/0/1/0", state_out, done_out, cfg_valid_out, error_out); end
        for (int w = 0; w < 8; w++) begin
            checks++; if (cfg_out[w*32 +: 32] !== m_cfg[w]) begin errors++; $display("FAIL basic_word%0d got %0h want %0h", w, cfg_out[w*32 +: 32], m_cfg[w]); end
        end
    endtask

    task automatic test_pause();
        int beat;
        start_run(8);
        for (beat = 0; beat < 3; beat++) begin
            resp_valid_in = 1; resp_idx_in = 4'(beat); resp_data_in = $urandom;
            m_cfg[beat] = resp_data_in;
            pause_in = (beat == 2);
            tick();
        end
        resp_idx_in = 4'd3; resp_data_in = 32'hDEAD0003;
        checks++; if (resp_ready_out !== 1'b0 || state_out !== S_PAUSE) begin
            errors++; $display("FAIL pause_enter got ready %b state %0h want 0/8", resp_ready_out, state_out); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (resp_ready_out !== 1'b0) begin errors++; $display("FAIL pause_hold got ready %b want 0", resp_ready_out); end
        end
        pause_in = 0;
        tick();
        checks++; if (resp_ready_out !== 1'b1) begin errors++; $display("FAIL pause_exit got ready %b want 1", resp_ready_out); end
        for (; beat < 8; beat++) begin
            resp_valid_in = 1; resp_idx_in = 4'(beat); resp_data_in = $urandom;
            m_cfg[beat] = resp_data_in;
            tick();
        end
        resp_valid_in = 0;
        checks++; if (done_out !== 1'b1) begin errors++; $display("FAIL pause_done got %b want 1", done_out); end
        tick();
        for (int w = 0; w < 8; w++) begin
            checks++; if (cfg_out[w*32 +: 32] !== m_cfg[w]) begin errors++; $display("FAIL pause_word%0d got %0h want %0h", w, cfg_out[w*32 +: 32], m_cfg[w]); end
        end
    endtask

    task automatic test_pause_last();
        start_run(8);
        for (int i = 0; i < 8; i++) begin
            resp_valid_in = 1; resp_idx_in = 4'(7 - i); resp_data_in = $urandom;
            m_cfg[7 - i] = resp_data_in;
            pause_in = (i == 7);
            tick();
        end
        resp_valid_in = 0; pause_in = 0;
        checks++; if (state_out !== S_DONE || done_out !== 1'b1) begin
            errors++; $display("FAIL pause_last got state %0h done %b want 10/1", state_out, done_out); end
        tick();
        checks++; if (state_out !== S_IDLE) begin errors++; $display("FAIL pause_last_idle got %0h want 2", state_out); end
    endtask

    task automatic test_flush();
        ap_rst_n = 0; tick(); ap_rst_n = 1; tick();
        for (int w = 0; w < 8; w++) m_cfg[w] = '0;
        start_run(8);
        for (int i = 0; i < 4; i++) begin
            resp_valid_in = 1; resp_idx_in = 4'(i); resp_data_in = 32'hD0 + 32'(i);
            m_cfg[i] = resp_data_in;
            tick();
        end
        flush_in = 1; resp_idx_in = 4'd4; resp_data_in = 32'hBAD4;
        tick();
        checks++; if (state_out !== S_FLUSH || resp_ready_out !== 1'b1 || busy_out !== 1'b1 || cfg_valid_out !== 1'b0) begin
            errors++; $display("FAIL flush_enter got state %0h ready %b busy %b cfgv %b want 20/1/1/0", state_out, resp_ready_out, busy_out, cfg_valid_out); end
        for (int k = 0; k < 5; k++) begin
            resp_idx_in = 4'(5 + (k % 3)); resp_data_in = 32'hBAD0 + 32'(k);
            tick();
            checks++; if (resp_ready_out !== 1'b1 || state_out !== S_FLUSH) begin
                errors++; $display("FAIL flush_drain got ready %b state %0h want 1/20", resp_ready_out, state_out); end
        end
        flush_in = 0; resp_valid_in = 0;
        tick();
        checks++; if (state_out !== S_IDLE || cfg_valid_out !== 1'b0 || done_out !== 1'b0) begin
            errors++; $display("FAIL flush_exit got state %0h cfgv %b done %b want 2/0/0", state_out, cfg_valid_out, done_out); end
        for (int w = 0; w < 8; w++) begin
            checks++; if (cfg_out[w*32 +: 32] !== m_cfg[w]) begin errors++; $display("FAIL flush_word%0d got %0h want %0h", w, cfg_out[w*32 +: 32], m_cfg[w]); end
        end
    endtask

    task automatic test_error_zero();
        start_run(2);
        resp_valid_in = 1; resp_idx_in = 4'd9; resp_data_in = 32'h99;
        tick();
        checks++; if (error_out !== 1'b1 || state_out !== S_BUSY) begin
            errors++; $display("FAIL err_set got err %b state %0h want 1/4", error_out, state_out); end
        resp_idx_in = 4'd1; resp_data_in = 32'h11; m_cfg[1] = 32'h11;
        tick();
        resp_valid_in = 0;
        checks++; if (done_out !== 1'b1 || error_out !== 1'b1 || cfg_valid_out !== 1'b1) begin
            errors++; $display("FAIL err_done got done %b err %b cfgv %b want 1/1/1", done_out, error_out, cfg_valid_out); end
        tick();
        start_in = 1; num_beats_in = 0;
        tick();
        start_in = 0;
        checks++; if (state_out !== S_DONE || done_out !== 1'b1 || error_out !== 1'b0 || cfg_valid_out !== 1'b1) begin
            errors++; $display("FAIL zero_done got state %0h done %b err %b cfgv %b want 10/1/0/1", state_out, done_out, error_out, cfg_valid_out); end
        tick();
        checks++; if (state_out !== S_IDLE) begin errors++; $display("FAIL zero_idle got %0h want 2", state_out); end
        for (int w = 0; w < 8; w++) begin
            checks++; if (cfg_out[w*32 +: 32] !== m_cfg[w]) begin errors++; $display("FAIL err_word%0d got %0h want %0h", w, cfg_out[w*32 +: 32], m_cfg[w]); end
        end
    endtask

    task automatic test_reset_midrun();
        start_run(8);
        for (int i = 0; i < 3; i++) begin
            resp_valid_in = 1; resp_idx_in = 4'(i); resp_data_in = $urandom;
            tick();
        end
        #2;
        ap_rst_n = 0;
        #1;
        for (int w = 0; w < 8; w++) m_cfg[w] = '0;
        checks++; if (state_out !== S_RESET || cfg_out !== '0) begin
            errors++; $display("FAIL midrst_state got state %0h cfg %0h want 1/0", state_out, cfg_out); end
        checks++; if ({resp_ready_out, cfg_valid_out, done_out, busy_out, error_out} !== 5'b0) begin
            errors++; $display("FAIL midrst_flags got %b want 00000", {resp_ready_out, cfg_valid_out, done_out, busy_out, error_out}); end
        quiet();
        tick();
        ap_rst_n = 1;
        tick();
        checks++; if (state_out !== S_IDLE) begin errors++; $display("FAIL midrst_release got %0h want 2", state_out); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 25; r++) begin
            int  n, got;
            bit  paused, err, hs, finished;
            n = $urandom_range(1, 8);
            start_run(n);
            got = 0; paused = 0; err = 0; finished = 0;
            for (int cyc = 0; cyc < 300; cyc++) begin
                resp_valid_in = ($urandom % 10) < 7;
                resp_idx_in   = 4'($urandom_range(0, 9));
                resp_data_in  = $urandom;
                pause_in      = ($urandom % 5) == 0;
                start_in      = ($urandom % 8) == 0;
                num_beats_in  = 16'($urandom_range(0, 5));
                checks++; if (resp_ready_out !== !paused) begin
                    errors++; $display("FAIL rnd_ready run %0d got %b want %b", r, resp_ready_out, !paused); end
                hs = resp_valid_in && !paused;
                if (hs) begin
                    got++;
                    if (resp_idx_in < 8) m_cfg[resp_idx_in[2:0]] = resp_data_in;
                    else                 err = 1;
                end
                tick();
                if (hs && got == n) begin
                    finished = 1;
                    checks++; if (done_out !== 1'b1 || error_out !== err || cfg_valid_out !== 1'b1) begin
                        errors++; $display("FAIL rnd_done run %0d got done %b err %b cfgv %b want 1/%b/1", r, done_out, error_out, cfg_valid_out, err); end
                    break;
                end
                checks++; if (done_out !== 1'b0 || error_out !== err) begin
                    errors++; $display("FAIL rnd_mid run %0d got done %b err %b want 0/%b", r, done_out, error_out, err); end
                paused = pause_in;
            end
            quiet();
            if (!finished) begin
                checks++; errors++;
                $display("FAIL rnd_timeout run %0d got %0d beats want %0d", r, got, n);
            end
            tick();
            checks++; if (state_out !== S_IDLE || cfg_valid_out !== 1'b1) begin
                errors++; $display("FAIL rnd_idle run %0d got state %0h cfgv %b want 2/1", r, state_out, cfg_valid_out); end
            for (int w = 0; w < 8; w++) begin
                checks++; if (cfg_out[w*32 +: 32] !== m_cfg[w]) begin
                    errors++; $display("FAIL rnd_word%0d run %0d got %0h want %0h", w, r, cfg_out[w*32 +: 32], m_cfg[w]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_pause();
        test_pause_last();
        test_flush();
        test_error_zero();
        test_reset_midrun();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
